// File: rtl/bitplane_fetcher.sv
// ============================================================================
// Module   : bitplane_fetcher
// Brief    : Reads LEDS pixel intensities from a synchronous frame RAM and
//            extracts one bit plane per load request for the BCM sequencer.
//            Planes are walked 0..BPP-1 and wrap back to 0.
// Options  : BUF2_EN - double-buffered frame; ram_addr MSB selects the display
//            page, which may flip only when a plane-0 fetch begins.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bitplane_fetcher #(
  parameter int LEDS = 8,
  parameter int BPP  = 12,
  parameter int AW   = 3
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            load_rq,
  output logic            data_ready,
  output logic [LEDS-1:0] data_out,
  output logic [3:0]      plane_idx,
  output logic            ram_rd,
  output logic [AW:0]     ram_addr,
  input  logic [BPP-1:0]  ram_data,
  input  logic            swap_rq,
  output logic            swap_ack,
  output logic            proto_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [AW-1:0] c_LAST_PIX   = AW'(LEDS - 1);
  localparam logic [3:0]    c_LAST_PLANE = 4'(BPP - 1);

  state_t          r_state;
  logic [3:0]      r_next_plane;   // plane the next fetch will extract
  logic [3:0]      r_fetch_plane;  // plane of the fetch in flight
  logic [AW-1:0]   r_pix;          // pixel address of the current read
  logic            r_rd_q;         // ram_rd delayed: ram_data is valid now
  logic [LEDS-1:0] r_shadow;       // assembly shift register, fills MSB-first
  logic            r_data_ready;
  logic [LEDS-1:0] r_data_out;
  logic [3:0]      r_plane_idx;
  logic            r_ram_rd;
  logic            r_proto_err;
  logic            w_page;
  logic            w_bit;
  logic            w_busy;
  logic            w_start;

  assign w_busy  = (r_state == S_FETCH) || (r_state == S_DRAIN);
  assign w_start = load_rq && !w_busy;
  assign w_bit   = ram_data[r_fetch_plane];

`ifdef BUF2_EN
  logic r_page;
  logic r_swap_ack;

  // Page flip is only considered when a plane-0 fetch begins, so a frame is
  // never displayed from two different pages.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_page     <= 1'b0;
      r_swap_ack <= 1'b0;
    end else begin
      r_swap_ack <= 1'b0;
      if (w_start && (r_next_plane == 4'd0) && swap_rq) begin
        r_page     <= ~r_page;
        r_swap_ack <= 1'b1;
      end
    end
  end

  assign w_page   = r_page;
  assign swap_ack = r_swap_ack;
`else
  logic w_unused_swap;

  assign w_unused_swap = swap_rq;
  assign w_page        = 1'b0;
  assign swap_ack      = 1'b0;
`endif

  // Fetch sequencer: issue LEDS reads, collect the returns, publish the byte.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_next_plane  <= 4'd0;
      r_fetch_plane <= 4'd0;
      r_pix         <= '0;
      r_rd_q        <= 1'b0;
      r_shadow      <= '0;
      r_data_ready  <= 1'b0;
      r_data_out    <= '0;
      r_plane_idx   <= 4'd0;
      r_ram_rd      <= 1'b0;
      r_proto_err   <= 1'b0;
    end else begin
      r_rd_q <= r_ram_rd;
      // Each return is shifted in at the top; after LEDS returns bit k
      // holds the pixel read from address k.
      if (r_rd_q) begin
        r_shadow <= {w_bit, r_shadow[LEDS-1:1]};
      end
      if (load_rq && w_busy) begin
        r_proto_err <= 1'b1;
      end
      case (r_state)
        S_IDLE, S_DONE: begin
          if (load_rq) begin
            r_state       <= S_FETCH;
            r_data_ready  <= 1'b0;
            r_fetch_plane <= r_next_plane;
            r_next_plane  <= (r_next_plane == c_LAST_PLANE) ? 4'd0
                                                            : r_next_plane + 4'd1;
            r_ram_rd      <= 1'b1;
            r_pix         <= '0;
          end
        end
        S_FETCH: begin
          if (r_pix == c_LAST_PIX) begin
            r_ram_rd <= 1'b0;
            r_state  <= S_DRAIN;
          end else begin
            r_pix <= r_pix + AW'(1);
          end
        end
        S_DRAIN: begin
          // The last return is on ram_data now; merge it straight in.
          r_data_out   <= {w_bit, r_shadow[LEDS-1:1]};
          r_plane_idx  <= r_fetch_plane;
          r_data_ready <= 1'b1;
          r_state      <= S_DONE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign data_ready = r_data_ready;
  assign data_out   = r_data_out;
  assign plane_idx  = r_plane_idx;
  assign ram_rd     = r_ram_rd;
  assign ram_addr   = {w_page, r_pix};
  assign proto_err  = r_proto_err;

endmodule

`default_nettype wire

// File: tb/tb_bitplane_fetcher.sv
// ============================================================================
// Module   : tb_bitplane_fetcher
// Brief    : Self-checking bench for bitplane_fetcher. A synchronous frame RAM
//            model feeds the DUT; expected bytes come from the RAM contents and
//            a plane/page model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bitplane_fetcher;

  localparam int LEDS = 8;
  localparam int BPP  = 12;
  localparam int AW   = 3;

  logic            clock = 1'b0;
  logic            reset;
  logic            load_rq;
  logic            data_ready;
  logic [LEDS-1:0] data_out;
  logic [3:0]      plane_idx;
  logic            ram_rd;
  logic [AW:0]     ram_addr;
  logic [BPP-1:0]  ram_data = '0;
  logic            swap_rq;
  logic            swap_ack;
  logic            proto_err;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference state: next plane, display page, sticky protocol error.
  int   m_next  = 0;
  logic m_page  = 1'b0;
  logic m_proto = 1'b0;

  logic [BPP-1:0] mem [0:2*LEDS-1];
  logic [AW:0]    rd_log [$];

  bitplane_fetcher #(.LEDS(LEDS), .BPP(BPP), .AW(AW)) dut (
    .clock      (clock),
    .reset      (reset),
    .load_rq    (load_rq),
    .data_ready (data_ready),
    .data_out   (data_out),
    .plane_idx  (plane_idx),
    .ram_rd     (ram_rd),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data),
    .swap_rq    (swap_rq),
    .swap_ack   (swap_ack),
    .proto_err  (proto_err)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Synchronous frame RAM: data valid the cycle after the read strobe.
  always @(posedge clock) if (ram_rd) ram_data <= mem[ram_addr];

  always @(posedge clock) if (ram_rd) rd_log.push_back(ram_addr);

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [LEDS-1:0] exp_byte(input logic pg, input int p);
    logic [LEDS-1:0] b;
    for (int k = 0; k < LEDS; k++) b[k] = mem[(pg ? LEDS : 0) + k][p];
    return b;
  endfunction

  // One load request; poke_at >= 0 re-pulses load_rq that many cycles later.
  task automatic run_fetch(input int poke_at);
    int              t0;
    int              n_low;
    int              p;
    logic            exp_ack;
    logic [LEDS-1:0] eb;
    @(posedge clock); #1;
    p       = m_next;
    exp_ack = 1'b0;
`ifdef BUF2_EN
    if (p == 0 && swap_rq) begin
      m_page  = ~m_page;
      exp_ack = 1'b1;
    end
`endif
    m_next = (p + 1) % BPP;
    if (poke_at >= 0) m_proto = 1'b1;
    eb = exp_byte(m_page, p);
    rd_log.delete();
    load_rq = 1'b1;
    t0      = cyc;
    @(posedge clock); #1;
    load_rq = 1'b0;
    check_val("swap_ack", 32'(swap_ack), 32'(exp_ack));
    n_low = 0;
    while (!data_ready && (cyc - t0) < 40) begin
      n_low++;
      load_rq = ((cyc - t0) == poke_at);
      @(posedge clock); #1;
    end
    load_rq = 1'b0;
    check_val("latency", 32'(cyc - t0), 32'(LEDS + 2));
    check_val("low_cycles", 32'(n_low), 32'(LEDS + 1));
    check_val("data_out", 32'(data_out), 32'(eb));
    check_val("plane_idx", 32'(plane_idx), 32'(p));
    check_val("rd_count", 32'(rd_log.size()), 32'(LEDS));
    for (int i = 0; i < rd_log.size() && i < LEDS; i++)
      check_val("rd_addr", 32'(rd_log[i]), 32'((m_page ? LEDS : 0) + i));
    check_val("proto_err", 32'(proto_err), 32'(m_proto));
    if (exp_ack) swap_rq = 1'b0;
  endtask

  initial begin
    int t0;
    reset   = 1'b1;
    load_rq = 1'b0;
    swap_rq = 1'b0;
    for (int k = 0; k < 2*LEDS; k++) mem[k] = BPP'(12'h001 << (k % LEDS));
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock); #1;
    check_val("rst_ready", 32'(data_ready), 32'h0);
    check_val("rst_data", 32'(data_out), 32'h0);
    check_val("rst_plane", 32'(plane_idx), 32'h0);
    check_val("rst_rd", 32'(ram_rd), 32'h0);
    check_val("rst_addr", 32'(ram_addr), 32'h0);
    check_val("rst_ack", 32'(swap_ack), 32'h0);
    check_val("rst_perr", 32'(proto_err), 32'h0);

    // Walking-one RAM: plane p<8 yields 1<<p, upper planes 0, 13th wraps.
    for (int n = 0; n < BPP + 1; n++) run_fetch(-1);

    // All-ones RAM: every plane yields 8'hFF.
    for (int k = 0; k < 2*LEDS; k++) mem[k] = '1;
    for (int n = 0; n < BPP; n++) run_fetch(-1);

    // Byte is held and never re-fetched without a request.
    rd_log.delete();
    repeat (6) @(posedge clock);
    #1;
    check_val("hold_ready", 32'(data_ready), 32'h1);
    check_val("no_refetch", 32'(rd_log.size()), 32'h0);

    // Request during FETCH: ignored, sticky error, counter advances once.
    run_fetch(4);
    run_fetch(-1);

    // Reset mid-fetch aborts immediately; next fetch is plane 0.
    @(posedge clock); #1;
    load_rq = 1'b1;
    t0      = cyc;
    @(posedge clock); #1;
    load_rq = 1'b0;
    while ((cyc - t0) < 5) begin
      @(posedge clock); #1;
    end
    check_val("mid_rd", 32'(ram_rd), 32'h1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check_val("abort_ready", 32'(data_ready), 32'h0);
    check_val("abort_rd", 32'(ram_rd), 32'h0);
    check_val("abort_perr", 32'(proto_err), 32'h0);
    m_next  = 0;
    m_page  = 1'b0;
    m_proto = 1'b0;
    run_fetch(-1);

    // Swap requested during plane 5, honoured only at the next plane-0 start.
    for (int k = 0; k < 2*LEDS; k++) mem[k] = BPP'($urandom);
    while (m_next != 5) run_fetch(-1);
    swap_rq = 1'b1;
    for (int n = 0; n < BPP - 4; n++) run_fetch(-1);
    swap_rq = 1'b0;

    // Randomized RAM contents, gaps and swap requests.
    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < 2*LEDS; k++) mem[k] = BPP'($urandom);
      if ($urandom_range(0, 3) == 0) swap_rq = 1'b1;
      repeat ($urandom_range(0, 3)) @(posedge clock);
      run_fetch(-1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
